conv2_frame_ctrl: RTL and testbench

CONV2_FRAME_CTRL -- requirements
Module: conv2_frame_ctrl

---
 rtl/conv2_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_conv2_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_frame_ctrl.sv
// conv2_frame_ctrl: sequences one conv2 frame through flush, pixel fill and
// result drain. It forwards pixel strobes, tracks the result row and column,
// and flags results that should not arrive and drains that never finish.
// Optional feature macro: CONV2_FRAME_CTRL_STATS_EN adds the frame_cnt output.
module conv2_frame_ctrl #(
   parameter int unsigned WIDTH     = 12,
   parameter int unsigned HEIGHT    = 12,
   parameter int unsigned KSIZE     = 5,
   parameter int unsigned DRAIN_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pix_valid_in,
   output logic        pix_ready,
   output logic        conv_valid_in,
   output logic        conv_rst_n,
   input  logic        conv_valid_out,
   output logic [3:0]  out_row,
   output logic [3:0]  out_col,
   output logic        frame_busy,
   output logic        frame_done,
   output logic        err_overflow,
   output logic        err_timeout
`ifdef CONV2_FRAME_CTRL_STATS_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int unsigned OUT_W_DIM = WIDTH - KSIZE + 1;
   localparam int unsigned OUT_H_DIM = HEIGHT - KSIZE + 1;
   localparam int unsigned NPIX      = WIDTH * HEIGHT;
   localparam int unsigned NOUT      = OUT_W_DIM * OUT_H_DIM;
   localparam int unsigned IN_W      = $clog2(NPIX + 1);
   localparam int unsigned OUT_W     = $clog2(NOUT + 1);
   localparam int unsigned TMO_W     = $clog2(DRAIN_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [IN_W-1:0]    in_cnt_q, in_cnt_d;
   logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
   logic [3:0]         out_row_q, out_row_d;
   logic [3:0]         out_col_q, out_col_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               err_ovf_q, err_ovf_d;
   logic               err_tmo_q, err_tmo_d;
   logic               accept;
   logic               res_win;
   logic               res_ok;

   // Next-state, counter and error-flag logic
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      tmo_cnt_d = tmo_cnt_q;
      err_ovf_d = err_ovf_q;
      err_tmo_d = err_tmo_q;

      accept  = (state_q == S_FILL) && pix_valid_in;
      res_win = ((state_q == S_FILL) || (state_q == S_DRAIN)) &&
                (out_cnt_q < OUT_W'(NOUT));
      res_ok  = conv_valid_out && res_win;

      // a result outside the counting window is an error and is not counted
      if (conv_valid_out && !res_win) begin
         err_ovf_d = 1'b1;
      end

      if (res_ok) begin
         out_cnt_d = out_cnt_q + 1'b1;
         if (out_col_q == 4'(OUT_W_DIM - 1)) begin
            out_col_d = 4'd0;
            out_row_d = out_row_q + 4'd1;
         end else begin
            out_col_d = out_col_q + 4'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            out_row_d = 4'd0;
            out_col_d = 4'd0;
            tmo_cnt_d = '0;
            state_d   = S_FILL;
         end
         S_FILL: begin
            if (accept) begin
               if (in_cnt_q == IN_W'(NPIX - 1)) begin
                  state_d = (out_cnt_d == OUT_W'(NOUT)) ? S_DONE : S_DRAIN;
               end else begin
                  in_cnt_d = in_cnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (res_ok) begin
               tmo_cnt_d = '0;
               if (out_cnt_q == OUT_W'(NOUT - 1)) begin
                  state_d = S_DONE;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (tmo_cnt_q == TMO_W'(DRAIN_MAX - 1)) begin
                  err_tmo_d = 1'b1;
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         out_row_q <= 4'd0;
         out_col_q <= 4'd0;
         tmo_cnt_q <= '0;
         err_ovf_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         out_row_q <= out_row_d;
         out_col_q <= out_col_d;
         tmo_cnt_q <= tmo_cnt_d;
         err_ovf_q <= err_ovf_d;
         err_tmo_q <= err_tmo_d;
      end
   end

`ifdef CONV2_FRAME_CTRL_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Completed-frame counter, wraps naturally
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (state_q == S_DONE) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   // Frame counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   // Handshake and status outputs decoded from state, held off during reset
   assign conv_rst_n    = ~(rst | (state_q == S_FLUSH));
   assign pix_ready     = ~rst & (state_q == S_FILL);
   assign conv_valid_in = pix_valid_in & pix_ready;
   assign frame_busy    = ~rst & (state_q != S_IDLE);
   assign frame_done    = ~rst & (state_q == S_DONE);
   assign out_row       = out_row_q;
   assign out_col       = out_col_q;
   assign err_overflow  = err_ovf_q;
   assign err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_conv2_frame_ctrl.sv
// Scoreboard bench for conv2_frame_ctrl: stimulus pushes expected result
// indices and frame-completion records; a negedge monitor pops and compares.
module tb_conv2_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        pix_valid_in;
   logic        pix_ready;
   logic        conv_valid_in;
   logic        conv_rst_n;
   logic        conv_valid_out;
   logic [3:0]  out_row;
   logic [3:0]  out_col;
   logic        frame_busy;
   logic        frame_done;
   logic        err_overflow;
   logic        err_timeout;
`ifdef CONV2_FRAME_CTRL_STATS_EN
   logic [15:0] frame_cnt;
`endif

   conv2_frame_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pix_valid_in   (pix_valid_in),
      .pix_ready      (pix_ready),
      .conv_valid_in  (conv_valid_in),
      .conv_rst_n     (conv_rst_n),
      .conv_valid_out (conv_valid_out),
      .out_row        (out_row),
      .out_col        (out_col),
      .frame_busy     (frame_busy),
      .frame_done     (frame_done),
      .err_overflow   (err_overflow),
      .err_timeout    (err_timeout)
`ifdef CONV2_FRAME_CTRL_STATS_EN
      ,
      .frame_cnt      (frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int row;
      int col;
   } res_t;

   typedef struct {
      int busy;
      int fwd;
      int ovf;
      int tmo;
   } done_t;

   res_t  res_q[$];
   done_t done_q[$];
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_done(input int busy, input int fwd, input int ovf, input int tmo);
      done_t d;
      d.busy = busy;
      d.fwd  = fwd;
      d.ovf  = ovf;
      d.tmo  = tmo;
      done_q.push_back(d);
   endtask

   // One frame: k=0 is the first FILL cycle; pixels presented for k<pix_hi,
   // results for r0<=k<r0+n; optional reset at k==abort_k.
   task automatic drive_frame(input int r0, input int n, input int ncyc,
                              input int pix_hi, input int abort_k);
      res_t r;
      start        = 1'b1;
      pix_valid_in = 1'b1;
      step();
      check("flush_conv_rst_n", 32'(conv_rst_n), 32'd0);
      check("flush_pix_ready", 32'(pix_ready), 32'd0);
      check("flush_no_fwd", 32'(conv_valid_in), 32'd0);
      check("flush_busy", 32'(frame_busy), 32'd1);
      step();
      start = 1'b0;
      check("fill_pix_ready", 32'(pix_ready), 32'd1);
      for (int k = 0; k < ncyc; k++) begin
         if (k == abort_k) begin
            rst            = 1'b1;
            pix_valid_in   = 1'b1;
            conv_valid_out = 1'b0;
            step();
            rst          = 1'b0;
            pix_valid_in = 1'b0;
            check("abort_busy", 32'(frame_busy), 32'd0);
            check("abort_row", 32'(out_row), 32'd0);
            check("abort_col", 32'(out_col), 32'd0);
            check("abort_pix_ready", 32'(pix_ready), 32'd0);
            return;
         end
         pix_valid_in   = (k < pix_hi);
         conv_valid_out = (k >= r0) && (k < r0 + n);
         if (conv_valid_out) begin
            r.row = (k - r0) / 8;
            r.col = (k - r0) % 8;
            res_q.push_back(r);
         end
         step();
      end
      pix_valid_in   = 1'b0;
      conv_valid_out = 1'b0;
      check("frame_idle", 32'(frame_busy), 32'd0);
   endtask

   // Monitor: compares results and frame completions against the queues
   int fwd_cnt   = 0;
   int busy_cnt  = 0;
   bit done_prev = 1'b0;

   always @(negedge clk) begin
      res_t  r;
      done_t d;
      if (rst) begin
         fwd_cnt   = 0;
         busy_cnt  = 0;
         done_prev = 1'b0;
      end else begin
         if (conv_valid_in) fwd_cnt++;
         if (frame_busy) busy_cnt++;
         else busy_cnt = 0;
         if (conv_valid_out) begin
            if (res_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL res_unexpected row=%0d col=%0d at %0t", out_row, out_col, $time);
            end else begin
               r = res_q.pop_front();
               check("res_row", 32'(out_row), 32'(r.row));
               check("res_col", 32'(out_col), 32'(r.col));
            end
         end
         if (frame_done) begin
            check("done_single_pulse", 32'(done_prev), 32'd0);
            if (done_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_unexpected busy=%0d at %0t", busy_cnt, $time);
            end else begin
               d = done_q.pop_front();
               check("done_busy_cycles", 32'(busy_cnt), 32'(d.busy));
               check("done_fwd_pixels", 32'(fwd_cnt), 32'(d.fwd));
               check("done_err_overflow", 32'(err_overflow), 32'(d.ovf));
               check("done_err_timeout", 32'(err_timeout), 32'(d.tmo));
            end
            fwd_cnt = 0;
         end
         done_prev = frame_done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      pix_valid_in   = 1'b1;
      conv_valid_out = 1'b0;
      step();
      step();
      // outputs held off while reset is asserted
      check("rst_pix_ready", 32'(pix_ready), 32'd0);
      check("rst_conv_valid_in", 32'(conv_valid_in), 32'd0);
      check("rst_conv_rst_n", 32'(conv_rst_n), 32'd0);
      check("rst_busy", 32'(frame_busy), 32'd0);
      rst          = 1'b0;
      pix_valid_in = 1'b0;
      step();
      check("idle_conv_rst_n", 32'(conv_rst_n), 32'd1);
      check("idle_busy", 32'(frame_busy), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
      check("idle_row", 32'(out_row), 32'd0);
      check("idle_col", 32'(out_col), 32'd0);
      check("idle_err_ovf", 32'(err_overflow), 32'd0);
      check("idle_err_tmo", 32'(err_timeout), 32'd0);

      // normal frame: 144 pixels then 64 results in DRAIN
      push_done(210, 144, 0, 0);
      drive_frame(144, 64, 215, 150, -1);

      // 64th result with the 144th pixel: no DRAIN cycle
      push_done(146, 144, 0, 0);
      drive_frame(80, 64, 150, 150, -1);

      // 60 results during FILL, none in DRAIN: timeout after 255 cycles
      push_done(401, 144, 0, 1);
      drive_frame(0, 60, 410, 144, -1);
      check("tmo_sticky", 32'(err_timeout), 32'd1);
      step();
      check("tmo_sticky_later", 32'(err_timeout), 32'd1);

      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("tmo_cleared", 32'(err_timeout), 32'd0);

      // result while IDLE: overflow, counters untouched
      begin
         res_t r;
         r.row = 0;
         r.col = 0;
         res_q.push_back(r);
      end
      conv_valid_out = 1'b1;
      step();
      conv_valid_out = 1'b0;
      check("idle_ovf_set", 32'(err_overflow), 32'd1);
      check("idle_ovf_row", 32'(out_row), 32'd0);
      check("idle_ovf_col", 32'(out_col), 32'd0);
      check("idle_ovf_busy", 32'(frame_busy), 32'd0);
      push_done(210, 144, 1, 0);
      drive_frame(144, 64, 215, 144, -1);
      check("ovf_sticky", 32'(err_overflow), 32'd1);

      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("ovf_cleared", 32'(err_overflow), 32'd0);

      // reset at pixel 70, then a full frame
      drive_frame(10, 20, 215, 144, 70);
      step();
      push_done(210, 144, 0, 0);
      drive_frame(144, 64, 215, 144, -1);
`ifdef CONV2_FRAME_CTRL_STATS_EN
      check("frame_cnt", 32'(frame_cnt), 32'd1);
`endif

      step();
      step();
      check("res_q_drained", 32'(res_q.size()), 32'd0);
      check("done_q_drained", 32'(done_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
